// File: rtl/pic8259_pkg.sv
// Shared types and bit-vector helpers for the 8259 interrupt controller slice.
// The acknowledge sequencer uses these now; the priority resolver will reuse them.
package pic8259_pkg;

  localparam int IRQ_COUNT = 8;
  localparam int IRQ_NUM_W = 3;

  // Vector reported when INTA# arrives with no request pending.
  localparam logic [IRQ_COUNT-1:0] SPURIOUS_IRQ = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    WAIT2,
    ACK2
  } ack_state_t;

  function automatic logic [7:0] rotate_right(input logic [7:0] value,
                                              input logic [2:0] amount);
    logic [15:0] shifted;
    shifted = {value, value} >> amount;
    return shifted[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] value,
                                             input logic [2:0] amount);
    logic [15:0] shifted;
    shifted = {value, value} << amount;
    return shifted[15:8];
  endfunction

  // Keep only the lowest set bit (two's-complement trick).
  function automatic logic [7:0] resolve_priority(input logic [7:0] value);
    return value & (~value + 8'd1);
  endfunction

  function automatic logic [2:0] bit2num(input logic [7:0] one_hot);
    logic [2:0] num;
    num = '0;
    for (int i = 0; i < 8; i++) begin
      if (one_hot[i]) num = 3'(i);
    end
    return num;
  endfunction

  function automatic logic [7:0] num2bit(input logic [2:0] num);
    logic [7:0] one_hot;
    one_hot = 8'd1 << num;
    return one_hot;
  endfunction

endpackage

// File: rtl/isr_priority_encoder.sv
// Picks the highest-priority set bit of a request/service vector under the
// current rotation. priority_rotate names the lowest-priority IR, so the
// vector is rotated so that IR(priority_rotate+1) lands on bit 0, the lowest
// set bit is isolated, and the result is rotated back.
module isr_priority_encoder
  import pic8259_pkg::*;
(
  input  logic [7:0] isr,
  input  logic [2:0] priority_rotate,
  output logic [7:0] highest_level
);

  logic [2:0] rot_amount;
  logic [7:0] rotated;
  logic [7:0] isolated;

  // Rotate, isolate the winner, undo the rotation.
  always_comb begin
    rot_amount    = priority_rotate + 3'd1;
    rotated       = rotate_right(isr, rot_amount);
    isolated      = resolve_priority(rotated);
    highest_level = rotate_left(isolated, rot_amount);
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259 INTA# acknowledge sequencer and In-Service Register owner.
// First INTA# pulse captures the winning request and sets its ISR bit;
// the second pulse drives the vector byte onto the data bus.
// Optional build macro AUTO_EOI_EN adds the auto_eoi input, which clears the
// acknowledged ISR bit right after the sequence ends.
//
// state | meaning
// IDLE  | waiting for the first INTA# falling edge
// ACK1  | first INTA# low, request captured and ISR bit set
// WAIT2 | between the two INTA# pulses
// ACK2  | second INTA# low, vector byte being driven
module interrupt_ack_sequencer
  import pic8259_pkg::*;
#(
  parameter int IRQ_W      = 8,
  parameter int VEC_BASE_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_initial_command_word_1,
  input  logic                  interrupt_acknowledge_n,
  input  logic [IRQ_W-1:0]      interrupt,
  input  logic [IRQ_W-1:0]      end_of_interrupt,
  input  logic [2:0]            priority_rotate,
  input  logic [VEC_BASE_W-1:0] interrupt_vector_base,
`ifdef AUTO_EOI_EN
  input  logic                  auto_eoi,
`endif
  output logic                  latch_in_service,
  output logic [IRQ_W-1:0]      acknowledge_interrupt,
  output logic                  end_of_acknowledge_sequence,
  output logic [IRQ_W-1:0]      in_service_register,
  output logic [IRQ_W-1:0]      highest_level_in_service,
  output logic [7:0]            vector_data,
  output logic                  vector_drive_enable
);

  ack_state_t state;

  logic             inta_prev;
  logic             inta_armed;
  logic             inta_fall;
  logic             inta_rise;
  logic             capture_fall;
  logic [IRQ_W-1:0] captured_irq;
  logic [IRQ_W-1:0] set_bits;
  logic [IRQ_W-1:0] auto_clear;
  logic [IRQ_W-1:0] isr_next;

  // INTA# edge detection. inta_armed blocks a "fall" for an INTA# that was
  // already low when reset released; it arms once INTA# is seen high.
  always_comb begin
    inta_fall = inta_prev & ~interrupt_acknowledge_n & inta_armed;
    inta_rise = ~inta_prev & interrupt_acknowledge_n;
  end

  // Request capture and ISR next-value; a set wins over a same-cycle clear.
  always_comb begin
    capture_fall = (state == IDLE) && inta_fall;
    captured_irq = (interrupt == '0) ? SPURIOUS_IRQ : interrupt;
    set_bits     = capture_fall ? interrupt : '0;
`ifdef AUTO_EOI_EN
    auto_clear   = (end_of_acknowledge_sequence && auto_eoi) ? acknowledge_interrupt : '0;
`else
    auto_clear   = '0;
`endif
    isr_next     = (in_service_register & ~(end_of_interrupt | auto_clear)) | set_bits;
  end

  // Track previous INTA# level and whether it has been seen high since reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inta_prev  <= 1'b1;
      inta_armed <= 1'b0;
    end else begin
      inta_prev <= interrupt_acknowledge_n;
      if (interrupt_acknowledge_n) inta_armed <= 1'b1;
    end
  end

  // Acknowledge FSM with registered outputs and ISR update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                       <= IDLE;
      acknowledge_interrupt       <= '0;
      in_service_register         <= '0;
      latch_in_service            <= 1'b0;
      end_of_acknowledge_sequence <= 1'b0;
      vector_drive_enable         <= 1'b0;
    end else if (write_initial_command_word_1) begin
      state                       <= IDLE;
      acknowledge_interrupt       <= '0;
      in_service_register         <= '0;
      latch_in_service            <= 1'b0;
      end_of_acknowledge_sequence <= 1'b0;
      vector_drive_enable         <= 1'b0;
    end else begin
      latch_in_service            <= 1'b0;
      end_of_acknowledge_sequence <= 1'b0;
      in_service_register         <= isr_next;
      case (state)
        IDLE: begin
          if (inta_fall) begin
            state                 <= ACK1;
            acknowledge_interrupt <= captured_irq;
            latch_in_service      <= 1'b1;
          end
        end
        ACK1: begin
          if (inta_rise) state <= WAIT2;
        end
        WAIT2: begin
          if (inta_fall) begin
            state               <= ACK2;
            vector_drive_enable <= 1'b1;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state                       <= IDLE;
            vector_drive_enable         <= 1'b0;
            end_of_acknowledge_sequence <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Vector byte follows the held acknowledge; zero when nothing is held.
  always_comb begin
    if (acknowledge_interrupt == '0) begin
      vector_data = '0;
    end else begin
      vector_data = {interrupt_vector_base, bit2num(acknowledge_interrupt)};
    end
  end

  isr_priority_encoder u_isr_priority_encoder (
    .isr             (in_service_register),
    .priority_rotate (priority_rotate),
    .highest_level   (highest_level_in_service)
  );

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench for interrupt_ack_sequencer: directed scenarios followed by random
// acknowledge sequences, with expectations queued by the driver and consumed
// by an output monitor.
module tb_interrupt_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       icw1;
  logic       inta_n;
  logic [7:0] interrupt;
  logic [7:0] eoi;
  logic [2:0] rot;
  logic [4:0] base;
`ifdef AUTO_EOI_EN
  logic       auto_eoi;
`endif
  logic       latch_in_service;
  logic [7:0] acknowledge_interrupt;
  logic       end_of_acknowledge_sequence;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [7:0] vector_data;
  logic       vector_drive_enable;

  always #5 clock = ~clock;

  interrupt_ack_sequencer dut (
    .clock                        (clock),
    .reset                        (reset),
    .write_initial_command_word_1 (icw1),
    .interrupt_acknowledge_n      (inta_n),
    .interrupt                    (interrupt),
    .end_of_interrupt             (eoi),
    .priority_rotate              (rot),
    .interrupt_vector_base        (base),
`ifdef AUTO_EOI_EN
    .auto_eoi                     (auto_eoi),
`endif
    .latch_in_service             (latch_in_service),
    .acknowledge_interrupt        (acknowledge_interrupt),
    .end_of_acknowledge_sequence  (end_of_acknowledge_sequence),
    .in_service_register          (in_service_register),
    .highest_level_in_service     (highest_level_in_service),
    .vector_data                  (vector_data),
    .vector_drive_enable          (vector_drive_enable)
  );

  typedef enum {EV_LATCH, EV_VEC, EV_END} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] ack;
    logic [7:0] isr;
    logic [7:0] vec;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] isr_model;
  logic       vde_prev = 1'b0;
  logic       auto_on;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Highest priority: walk IR numbers starting just above the lowest-priority one.
  function automatic logic [7:0] model_highest(input logic [7:0] isr, input logic [2:0] r);
    logic [7:0] one;
    int n;
    one = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      n = (int'(r) + k) % 8;
      if (isr[n]) return one << n;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] model_vec(input logic [4:0] b, input logic [7:0] a);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) if (a[i]) idx = i;
    return {b, idx[2:0]};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Output monitor: consumes one queued expectation per DUT output event.
  always @(negedge clock) begin
    if (!reset) begin
      if (latch_in_service) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_LATCH) begin
          checks++; errors++;
          $display("FAIL unexpected_latch: ack=%h isr=%h at %0t", acknowledge_interrupt, in_service_register, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check8("latch_ack", acknowledge_interrupt, mon_e.ack);
          check8("latch_isr", in_service_register, mon_e.isr);
        end
      end
      if (vector_drive_enable && !vde_prev) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_VEC) begin
          checks++; errors++;
          $display("FAIL unexpected_drive_enable: vec=%h at %0t", vector_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check8("vector_data", vector_data, mon_e.vec);
        end
      end
      if (end_of_acknowledge_sequence) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_END) begin
          checks++; errors++;
          $display("FAIL unexpected_end_pulse: isr=%h at %0t", in_service_register, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check8("end_isr", in_service_register, mon_e.isr);
          check8("end_drive_enable", {7'd0, vector_drive_enable}, 8'h00);
          check8("end_highest", highest_level_in_service, model_highest(mon_e.isr, rot));
        end
      end
    end
    vde_prev = vector_drive_enable;
  end

  // One full (or partial, stopping in WAIT2) INTA# double pulse.
  task automatic run_ack(input logic [7:0] irq, input logic [7:0] eoi_at_fall, input bit stop_in_wait2);
    logic [7:0] ack_exp;
    ack_exp   = (irq == 8'h00) ? 8'h80 : irq;
    isr_model = (isr_model & ~eoi_at_fall) | irq;
    exp_q.push_back('{EV_LATCH, ack_exp, isr_model, 8'h00});
    interrupt = irq;
    eoi       = eoi_at_fall;
    inta_n    = 1'b0;
    step(1);
    eoi       = 8'h00;
    interrupt = 8'($urandom);
    step($urandom_range(0, 2));
    inta_n = 1'b1;
    step($urandom_range(1, 3));
    if (stop_in_wait2) return;
    exp_q.push_back('{EV_VEC, ack_exp, isr_model, model_vec(base, ack_exp)});
    inta_n = 1'b0;
    step($urandom_range(1, 3));
    exp_q.push_back('{EV_END, ack_exp, isr_model, 8'h00});
    inta_n = 1'b1;
    step(1);
    if (auto_on) isr_model = isr_model & ~ack_exp;
    step(1);
    check8("post_seq_isr", in_service_register, isr_model);
    check8("post_seq_highest", highest_level_in_service, model_highest(isr_model, rot));
  endtask

  task automatic do_icw1();
    icw1 = 1'b1;
    step(1);
    icw1 = 1'b0;
    isr_model = 8'h00;
    check8("icw1_isr", in_service_register, 8'h00);
    check8("icw1_ack", acknowledge_interrupt, 8'h00);
  endtask

  logic [7:0] rot_exp [3];
  logic [2:0] rot_val [3];
  logic [7:0] irq_r;

  initial begin
    reset = 1'b1; icw1 = 1'b0; inta_n = 1'b1; interrupt = 8'h00; eoi = 8'h00;
    rot = 3'd7; base = 5'h08; isr_model = 8'h00; auto_on = 1'b0;
`ifdef AUTO_EOI_EN
    auto_eoi = 1'b0;
`endif
    step(2);
    check8("rst_latch", {7'd0, latch_in_service}, 8'h00);
    check8("rst_ack", acknowledge_interrupt, 8'h00);
    check8("rst_end", {7'd0, end_of_acknowledge_sequence}, 8'h00);
    check8("rst_isr", in_service_register, 8'h00);
    check8("rst_highest", highest_level_in_service, 8'h00);
    check8("rst_vector", vector_data, 8'h00);
    check8("rst_vde", {7'd0, vector_drive_enable}, 8'h00);
    reset = 1'b0;
    step(2);

    // Basic sequence: IR2 with base 0x08 -> vector 0x42.
    run_ack(8'h04, 8'h00, 1'b0);
    check8("t1_isr", in_service_register, 8'h04);
    check8("t1_vector", vector_data, 8'h42);

    // Clear and set in the same cycle.
    run_ack(8'h10, 8'h00, 1'b0);
    run_ack(8'h01, 8'h10, 1'b0);
    check8("t2_isr", in_service_register, 8'h05);

    // Rotation of highest level for ISR=0x91.
    do_icw1();
    run_ack(8'h01, 8'h00, 1'b0);
    run_ack(8'h10, 8'h00, 1'b0);
    run_ack(8'h80, 8'h00, 1'b0);
    check8("t3_isr", in_service_register, 8'h91);
    rot_val[0] = 3'd7; rot_exp[0] = 8'h01;
    rot_val[1] = 3'd3; rot_exp[1] = 8'h10;
    rot_val[2] = 3'd6; rot_exp[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      rot = rot_val[i];
      #1;
      check8("t3_highest", highest_level_in_service, rot_exp[i]);
    end
    rot = 3'd7;

    // Spurious acknowledge: IR7 reported, ISR untouched.
    run_ack(8'h00, 8'h00, 1'b0);
    check8("t4_ack", acknowledge_interrupt, 8'h80);
    check8("t4_isr", in_service_register, 8'h91);
    check8("t4_vec_low", {5'd0, vector_data[2:0]}, 8'h07);

    // Async reset while in WAIT2, INTA# low across release.
    run_ack(8'h02, 8'h00, 1'b1);
    inta_n = 1'b0;
    reset  = 1'b1;
    #1;
    exp_q.delete();
    isr_model = 8'h00;
    check8("t5_latch", {7'd0, latch_in_service}, 8'h00);
    check8("t5_ack", acknowledge_interrupt, 8'h00);
    check8("t5_isr", in_service_register, 8'h00);
    check8("t5_vector", vector_data, 8'h00);
    check8("t5_vde", {7'd0, vector_drive_enable}, 8'h00);
    step(2);
    reset = 1'b0;
    step(3);
    check8("t5_no_fall_isr", in_service_register, 8'h00);
    check8("t5_no_fall_ack", acknowledge_interrupt, 8'h00);
    inta_n = 1'b1;
    step(1);
    run_ack(8'h20, 8'h00, 1'b0);
    check8("t5_after_isr", in_service_register, 8'h20);

    // Auto-EOI (or plain hold without the feature).
    do_icw1();
`ifdef AUTO_EOI_EN
    auto_eoi = 1'b1;
    auto_on  = 1'b1;
`endif
    run_ack(8'h08, 8'h00, 1'b0);
`ifdef AUTO_EOI_EN
    check8("t6_isr", in_service_register, 8'h00);
    auto_eoi = 1'b0;
    auto_on  = 1'b0;
`else
    check8("t6_isr", in_service_register, 8'h08);
`endif

    // Random sequences.
    for (int n = 0; n < 40; n++) begin
      base = 5'($urandom);
      rot  = 3'($urandom);
`ifdef AUTO_EOI_EN
      auto_eoi = 1'($urandom);
      auto_on  = auto_eoi;
`endif
      if ($urandom_range(0, 7) == 0) irq_r = 8'h00;
      else irq_r = 8'h01 << $urandom_range(0, 7);
      run_ack(irq_r, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        eoi = 8'($urandom);
        isr_model = isr_model & ~eoi;
        step(1);
        eoi = 8'h00;
        check8("gap_eoi_isr", in_service_register, isr_model);
      end
      if ($urandom_range(0, 9) == 0) do_icw1();
      step($urandom_range(0, 2));
    end

    step(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
